// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-to-serial UART transmitter, 8N1, LSB first, with a
// one-byte holding register so consecutive frames go out with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit follows the data bits (11-bit frame); PARITY_ODD
//                selects the sense (0 = even, 1 = odd).
//   undefined -> 10-bit frame, no parity logic; PARITY_ODD is ignored.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit time (>= 2)
//   PARITY_ODD    parity sense, only used with UART_TX_PARITY_EN
// Ports:
//   Clk      in   system clock, posedge
//   Reset    in   synchronous, active-high
//   XMitGo   in   load strobe; accepted when the holding register is empty
//   TxData   in   byte to send, sampled on an accepted XMitGo edge
//   TxEmpty  out  holding register empty, a new byte may be accepted
//   TxBusy   out  frame in progress
//   TxDone   out  one-cycle pulse in the first cycle after a stop bit
//   TxD      out  registered serial line, idle high
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       XMitGo,
  input  logic [7:0] TxData,
  output logic       TxEmpty,
  output logic       TxBusy,
  output logic       TxDone,
  output logic       TxD
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic            bit_end;
  logic            load_shift;

`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`else
  logic            unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign bit_end = (cnt_q == CntMax);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    load_shift   = 1'b0;
    // Every state change happens on bit_end, so the wrap to zero doubles as
    // the clear-on-entry of the baud counter.
    cnt_d        = bit_end ? '0 : cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    // Accept and transfer are mutually exclusive on hold_valid_q.
    if (XMitGo && !hold_valid_q) begin
      hold_d       = TxData;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (hold_valid_q) load_shift = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (hold_valid_q) load_shift = 1'b1;
          else              state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_shift) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      state_d      = StStart;
`ifdef UART_TX_PARITY_EN
      parity_d     = (^hold_q) ^ PARITY_ODD;
`endif
    end

    // Line level is registered from the next state so TxD lines up with state_q.
    unique case (state_d)
      StIdle:   txd_d = 1'b1;
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      StStop:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      txd_q        <= 1'b1;
      done_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      txd_q        <= txd_d;
      done_q       <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign TxEmpty = ~hold_valid_q;
  assign TxBusy  = (state_q != StIdle);
  assign TxDone  = done_q;
  assign TxD     = txd_q;

endmodule
